// File: rtl/bit_order_deser.sv
// Serial-to-parallel deserialiser with per-word MSB/LSB-first placement, one-word output buffer
// and valid/ready handshake. Define BIT_ORDER_DESER_PARITY_EN for a trailing even-parity bit.
module bit_order_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             msb_first,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef BIT_ORDER_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef BIT_ORDER_DESER_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    logic [CW-1:0]    r_count;
    logic             r_order;
    logic             r_busy;
    logic [WIDTH-1:0] r_coll;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    logic             w_last;
    logic             w_accept;
    logic             w_complete;
    logic             w_order;
    logic             w_data_bit;
    logic [CW-1:0]    w_idx;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_coll_next;

    assign w_last     = (r_count == LAST);
    // Only the word-completing bit can stall, and only while the buffered word is held.
    assign in_ready   = !(w_last && r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_complete = w_accept && w_last;
    // The first bit of a word uses the live pin; later bits use the latched order.
    assign w_order    = (r_count == '0) ? msb_first : r_order;
    assign w_data_bit = (r_count < CW'(WIDTH));
    assign w_idx      = w_order ? (CW'(WIDTH - 1) - r_count) : r_count;

    always_comb begin
        w_coll_next = r_coll;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (w_accept && w_data_bit && (w_idx == CW'(i))) begin
                w_coll_next[i] = in_bit;
            end
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (flush || w_complete) begin
            w_count_next = '0;
        end else if (w_accept) begin
            w_count_next = r_count + 1'b1;
        end
    end

`ifdef BIT_ORDER_DESER_PARITY_EN
    logic r_parity_err;
    logic w_parity_err;

    // On completion in_bit is the parity bit itself and the collector holds all data bits.
    assign w_parity_err = (^w_coll_next) ^ in_bit;
    assign parity_err   = r_parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_complete) begin
            r_parity_err <= w_parity_err;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_order     <= 1'b0;
            r_busy      <= 1'b0;
            r_coll      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_busy  <= (w_count_next != '0);
            r_coll  <= w_coll_next;
            if (w_accept && (r_count == '0)) begin
                r_order <= msb_first;
            end
            if (w_complete) begin
                r_out_data  <= w_coll_next;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bit_order_deser.sv
// Self-checking bench for bit_order_deser: directed scenarios plus a randomized run against a
// queue-based word-assembly model.
module tb_bit_order_deser;

    localparam int unsigned WIDTH = 8;
`ifdef BIT_ORDER_DESER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             msb_first;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef BIT_ORDER_DESER_PARITY_EN
    logic             parity_err;
`endif

    int n_vec;
    int n_err;

    bit_order_deser #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .msb_first (msb_first),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef BIT_ORDER_DESER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream bit k of word w: data bits in the requested order, then even parity if enabled.
    function automatic logic sbit(input logic [WIDTH-1:0] w, input logic msb, input int k);
        if (k >= int'(WIDTH)) return ^w;
        return msb ? w[WIDTH-1-k] : w[k];
    endfunction

    task automatic send_bits(input logic [WIDTH-1:0] w, input logic msb, input int from,
                             input int to);
        for (int k = from; k < to; k++) begin
            in_valid  = 1'b1;
            in_bit    = sbit(w, msb, k);
            msb_first = msb;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; msb_first = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 00", out_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_msb_first();
        out_ready = 1'b1;
        send_bits(8'hB0, 1'b1, 0, NB);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL msb_valid got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'hB0) begin n_err++; $display("FAIL msb_data got %h want b0", out_data); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL msb_pulse got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL msb_busy got %b want 0", busy); end
    endtask

    task automatic test_lsb_first();
        out_ready = 1'b1;
        send_bits(8'h0D, 1'b0, 0, NB);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lsb_valid got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'h0D) begin n_err++; $display("FAIL lsb_data got %h want 0d", out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_order_latch();
        out_ready = 1'b1;
        send_bits(8'hB0, 1'b1, 0, 2);
        for (int k = 2; k < NB; k++) begin
            in_valid  = 1'b1;
            in_bit    = sbit(8'hB0, 1'b1, k);
            msb_first = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_vec++; if (out_data !== 8'hB0) begin n_err++; $display("FAIL latch_data got %h want b0", out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        send_bits(8'hB0, 1'b1, 0, NB);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid0 got %b want 1", out_valid); end
        send_bits(8'hFF, 1'b1, 0, NB - 1);
        in_valid  = 1'b1;
        in_bit    = sbit(8'hFF, 1'b1, NB - 1);
        msb_first = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_vec++; if (out_data !== 8'hB0) begin n_err++; $display("FAIL bp_hold got %h want b0", out_data); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy got %b want 1", busy); end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_cont got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL bp_data got %h want ff", out_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle got %b want 0", busy); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send_bits(8'h55, 1'b1, 0, 3);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fl_busy got %b want 1", busy); end
        flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fl_clear got %b want 0", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_noword got %b want 0", out_valid); end
        send_bits(8'h01, 1'b1, 0, NB);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fl_valid got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'h01) begin n_err++; $display("FAIL fl_data got %h want 01", out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_bits(8'hA5, 1'b1, 0, NB);
        send_bits(8'h3C, 1'b1, 0, 5);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar_busy0 got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b want 0", busy); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL ar_data got %h want 00", out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_bits(8'hC3, 1'b0, 0, NB);
        n_vec++; if (out_data !== 8'hC3) begin n_err++; $display("FAIL ar_word got %h want c3", out_data); end
        @(posedge clk); #1;
    endtask

`ifdef BIT_ORDER_DESER_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        for (int p = 1; p >= 0; p--) begin
            send_bits(8'hB0, 1'b1, 0, WIDTH);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL par_early got %b want 0", out_valid); end
            in_valid = 1'b1; in_bit = p[0];
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_vec++; if (parity_err !== ~p[0]) begin n_err++; $display("FAIL par_err got %b want %b", parity_err, ~p[0]); end
            n_vec++; if (out_data !== 8'hB0) begin n_err++; $display("FAIL par_data got %h want b0", out_data); end
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_random();
        logic             iv, ib, ms, orr, fl, exp_ready, acc, comp, morder, mvalid, merr, perr;
        logic [WIDTH-1:0] mdata, w;
        bit               q[$];
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        morder = 1'b0; mvalid = 1'b0; mdata = '0; merr = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            iv  = ($urandom_range(0, 3) != 0);
            ib  = 1'($urandom_range(0, 1));
            ms  = 1'($urandom_range(0, 1));
            orr = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 15) == 0);
            in_valid = iv; in_bit = ib; msb_first = ms; out_ready = orr; flush = fl;
            exp_ready = !((q.size() == NB - 1) && mvalid && !orr);
            @(negedge clk);
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, in_ready, exp_ready); end
            acc  = iv && exp_ready && !fl;
            comp = 1'b0;
            if (fl) begin
                q.delete();
            end else if (acc) begin
                if (q.size() == 0) morder = ms;
                q.push_back(ib);
                if (q.size() == NB) begin
                    comp = 1'b1;
                    w    = '0;
                    perr = 1'b0;
                    for (int k = 0; k < NB; k++) begin
                        perr ^= q[k];
                        if (k < int'(WIDTH)) begin
                            if (morder) w[WIDTH-1-k] = q[k];
                            else        w[k] = q[k];
                        end
                    end
                    q.delete();
                end
            end
            if (comp) begin
                mvalid = 1'b1; mdata = w; merr = perr;
            end else if (mvalid && orr) begin
                mvalid = 1'b0;
            end
            @(posedge clk); #1;
            n_vec++; if (out_valid !== mvalid) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, out_valid, mvalid); end
            n_vec++; if (out_data !== mdata) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, out_data, mdata); end
            n_vec++; if (busy !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, q.size() != 0); end
`ifdef BIT_ORDER_DESER_PARITY_EN
            n_vec++; if (parity_err !== merr) begin n_err++; $display("FAIL rnd_perr cyc %0d got %b want %b", cyc, parity_err, merr); end
`endif
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_order_latch();
        test_back_pressure();
        test_flush();
        test_async_reset();
`ifdef BIT_ORDER_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bit_order_deser.md
Name: bit_order_deser

Overview:
- Parametrised serial-to-parallel deserialiser that packs a bit stream into WIDTH-bit words.
- Bit-to-index ordering is selectable per word: MSB-first or LSB-first.
- Adds valid/ready handshake, one-word output buffering and input back-pressure.
- Successor to the fixed 2-bit array-ordering dataflow block; used wherever serial links feed parallel datapaths.

Parameters:
- WIDTH, 8, word width in bits; legal range >= 2. Internal bit counter width is $clog2(WIDTH+1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_ready  output  1  block accepts in_bit this cycle.
- msb_first  input  1  1: first bit of word -> out_data[WIDTH-1]; 0: first bit -> out_data[0].
- flush  input  1  synchronous discard of the partial word.
- out_data  output  WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  partial word in progress (count != 0).

Behaviour:
- Reset (async, rst_n=0): out_data=0, out_valid=0, busy=0, count=0, order latch=0, parity_err=0 (if built). Effect is immediate, not clock-gated. A partial word is lost.
- Bit accept: accept = in_valid & in_ready & !flush.
- Order latch: msb_first is sampled on the accept of the first bit of a word (count==0). Changes mid-word are ignored until the next word.
- Placement: bit k of a word (k = 0..WIDTH-1, arrival order) is written to index WIDTH-1-k when the latch=1, or index k when the latch=0. Placement is direct; no shifting of earlier bits.
- Completion: the accept with count==WIDTH-1 (the last data bit) completes the word.
- On completion, the next clock edge loads the collector into out_data, sets out_valid=1 and sets count=0. Latency: out_valid rises 1 cycle after the last bit is accepted.
- Output handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_valid stays high and out_data stays stable until transfer.
  - Transfer with no completion in the same cycle: out_valid=0 next cycle; out_data retains its value.
  - Transfer and completion in the same cycle: the new word loads and out_valid stays 1. No bubble, no loss.
- Back-pressure: in_ready = !(count==WIDTH-1 && out_valid && !out_ready). This is combinational from out_ready. Only the final bit of a word stalls; earlier bits are always accepted.
- Flush:
  - Sets count=0 and busy=0.
  - A bit presented in the same cycle is dropped.
  - The output register and out_valid are unaffected.
  - Flush has priority over completion in the same cycle: no word is produced.
- busy = (count != 0), registered.
- Wrap: count never exceeds WIDTH-1 (WIDTH with parity). After completion it returns to 0.
- in_valid=0 cycles between bits are allowed. Collector state holds indefinitely.

Optional Feature:
- Macro: BIT_ORDER_DESER_PARITY_EN.
- Defined:
  - Each word carries one extra trailing even-parity bit after its WIDTH data bits. Count runs 0..WIDTH and completion occurs on the parity bit. in_ready stall applies at count==WIDTH.
  - Output port parity_err (1 bit) is added. It is registered with out_data, and is 1 when XOR of the data bits and the parity bit is 1.
  - The parity bit is never stored in out_data.
- Undefined:
  - No parity_err port.
  - Words are exactly WIDTH bits.

Test Plan:
- WIDTH=8, msb_first=1, out_ready=1, bits 1,0,1,1,0,0,0,0 on consecutive cycles -> out_data=8'hB0; out_valid high for 1 cycle, one cycle after the 8th bit.
- Same bits with msb_first=0 -> out_data=8'h0D. Toggle msb_first to 0 after bit 2 of an MSB-first word -> still 8'hB0.
- out_ready=0, word 8'hB0 completes, then stream 8'hFF (msb_first=1) -> in_ready=0 at the 8th bit; out_data holds 8'hB0. Raise out_ready for 1 cycle -> 8'hB0 transfers, the 8th bit is accepted, and out_data=8'hFF appears with out_valid continuous.
- Send 3 bits, assert flush for 1 cycle with in_valid=1 -> busy=0, bit dropped. The next 8 bits 0,0,0,0,0,0,0,1 (msb_first=1) -> 8'h01.
- Drop rst_n mid-word after 5 bits, with out_valid=1 -> out_valid, busy and out_data are 0 immediately, before the next clk edge. After release, a full word is assembled correctly.
- With BIT_ORDER_DESER_PARITY_EN:
  - 8'hB0 followed by parity bit 1 -> parity_err=0.
  - 8'hB0 followed by parity bit 0 -> parity_err=1, out_data=8'hB0.
